// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl: reorder-buffer index allocation, completion tracking and
// in-order retirement for an 8-entry ROB, with mispredict rollback.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   dispatch_*                   allocation request from decode/dispatch
//   rob_ready, DC_rob_idx        entry available / index the next dispatch gets
//   wb_valid, wb_rob_idx         completion from a functional unit
//   mispredict, mis_rob_idx      branch rollback request
//   commit_*                     head retirement and old-preg release
//   rob_empty, rob_count         occupancy status
//   perf_commit_cnt, perf_full_cyc  (only with ROB_PERF_CNT_EN defined)
//
// Optional feature macro: ROB_PERF_CNT_EN adds commit and full-cycle counters.
module rob_alloc_ctrl #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned PREG_W      = 7,
  parameter int unsigned RECOVER_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_valid,
  input  logic              dispatch_has_rd,
  input  logic [PREG_W-1:0] dispatch_P_rd_old,
  output logic              rob_ready,
  output logic [IDX_W-1:0]  DC_rob_idx,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_rob_idx,
  input  logic              mispredict,
  input  logic [IDX_W-1:0]  mis_rob_idx,
  output logic              commit_valid,
  output logic [IDX_W-1:0]  commit_rob_idx,
  output logic              commit_free,
  output logic [PREG_W-1:0] commit_P_rd_old,
  output logic              rob_empty,
  output logic [IDX_W:0]    rob_count
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_commit_cnt,
  output logic [31:0]       perf_full_cyc
`endif
);

  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned RCNT_W = 4;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [RCNT_W-1:0]              rcnt_q, rcnt_d;
  logic [IDX_W-1:0]               head_q, head_d;
  logic [IDX_W-1:0]               tail_q, tail_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [DEPTH-1:0]               valid_q, valid_d;
  logic [DEPTH-1:0]               done_q, done_d;
  logic [DEPTH-1:0]               has_rd_q, has_rd_d;
  logic [DEPTH-1:0][PREG_W-1:0]   prd_q, prd_d;

  logic             alloc;
  logic             mis_take;
  logic [IDX_W-1:0] mis_off;
  logic [IDX_W-1:0] ent_off;

  // Mispredict blocks alloc and retire even when its index turns out invalid.
  assign rob_ready       = (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH));
  assign alloc           = dispatch_valid && rob_ready && !mispredict;
  assign commit_valid    = valid_q[head_q] && done_q[head_q] && !mispredict;
  assign mis_take        = mispredict && valid_q[mis_rob_idx];
  assign DC_rob_idx      = tail_q;
  assign commit_rob_idx  = head_q;
  assign commit_free     = commit_valid ? has_rd_q[head_q] : 1'b0;
  assign commit_P_rd_old = commit_valid ? prd_q[head_q] : '0;
  assign rob_empty       = (count_q == '0);
  assign rob_count       = count_q;

  // Next-state: writeback, retire, allocate, then rollback overrides.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    valid_d  = valid_q;
    done_d   = done_q;
    has_rd_d = has_rd_q;
    prd_d    = prd_q;
    ent_off  = '0;
    mis_off  = mis_rob_idx - head_q;

    if (wb_valid && valid_q[wb_rob_idx] && !(alloc && (wb_rob_idx == tail_q))) begin
      done_d[wb_rob_idx] = 1'b1;
    end

    if (commit_valid) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + IDX_W'(1);
    end

    if (alloc) begin
      valid_d[tail_q]  = 1'b1;
      done_d[tail_q]   = 1'b0;
      has_rd_d[tail_q] = dispatch_has_rd;
      prd_d[tail_q]    = dispatch_P_rd_old;
      tail_d           = tail_q + IDX_W'(1);
    end

    count_d = count_q + CNT_W'(alloc) - CNT_W'(commit_valid);

    if (mis_take) begin
      // Age is the ring distance from head; squash everything younger.
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_off = IDX_W'(i) - head_q;
        if (ent_off > mis_off) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
      tail_d  = mis_rob_idx + IDX_W'(1);
      count_d = CNT_W'(mis_off) + CNT_W'(1);
      state_d = ST_RECOVER;
      rcnt_d  = RCNT_W'(RECOVER_CYC - 1);
    end else if (state_q == ST_RECOVER) begin
      if (rcnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        rcnt_d = rcnt_q - RCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      rcnt_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      done_q   <= '0;
      has_rd_q <= '0;
      prd_q    <= '0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      has_rd_q <= has_rd_d;
      prd_q    <= prd_d;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_cnt_q, perf_commit_cnt_d;
  logic [31:0] perf_full_cyc_q, perf_full_cyc_d;

  // Free-running event counters, wrapping at 2^32.
  always_comb begin
    perf_commit_cnt_d = perf_commit_cnt_q + 32'(commit_valid);
    perf_full_cyc_d   = perf_full_cyc_q + 32'(count_q == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_commit_cnt_q <= '0;
      perf_full_cyc_q   <= '0;
    end else begin
      perf_commit_cnt_q <= perf_commit_cnt_d;
      perf_full_cyc_q   <= perf_full_cyc_d;
    end
  end

  assign perf_commit_cnt = perf_commit_cnt_q;
  assign perf_full_cyc   = perf_full_cyc_q;
`endif

endmodule
